// File: rtl/multu8_seq_pkg.sv
// ============================================================================
//  Module : multu8_seq_pkg
//  Brief  : Shared constants and FSM encoding for the multu8_seq multiplier.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multu8_seq_pkg;

    localparam int MUL_N     = 8;
    localparam int MUL_STEPS = 8;
    localparam int MUL_ADD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/multu8_seq_addu10.sv
// ============================================================================
//  Module : addu10
//  Brief  : Combinational ripple-carry adder; carry out of the MSB is dropped.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addu10 #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < W - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

`default_nettype wire

// File: rtl/multu8_seq.sv
// ============================================================================
//  Module : multu8_seq
//  Brief  : Iterative 8x8 unsigned shift-add multiplier, one step per clock,
//           valid/ready handshake on both sides.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multu8_seq
    import multu8_seq_pkg::*;
#(
    parameter int N     = MUL_N,
    parameter int ADD_W = MUL_ADD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*N-1:0] product,
    output logic          busy
);

    localparam int          CNT_W    = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     m;
    logic [N:0]       p;
    logic [N-1:0]     q;
    logic [CNT_W-1:0] cnt;

    logic [ADD_W-1:0] add_a;
    logic [ADD_W-1:0] add_b;
    logic [ADD_W-1:0] add_out;
    logic [ADD_W-1:0] step_sel;

    assign add_a = {{(ADD_W-N-1){1'b0}}, p};
    assign add_b = {{(ADD_W-N){1'b0}}, m};

    addu10 #(.W(ADD_W)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_out)
    );

    // Bit ADD_W-1 of the sum is provably zero; routing it into P[N] keeps the
    // 17-bit right shift exact without a separate carry path.
    assign step_sel = q[0] ? add_out : {1'b0, p};

    assign in_ready = (state == ST_IDLE) && !rst;
    assign busy     = (state == ST_CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = in_valid  ? ST_CALC : ST_IDLE;
            ST_CALC: state_next = (cnt == CNT_LAST) ? ST_DONE : ST_CALC;
            ST_DONE: state_next = out_ready ? ST_IDLE : ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m         <= '0;
            p         <= '0;
            q         <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        m   <= a;
                        p   <= '0;
                        q   <= b;
                        cnt <= '0;
                    end
                end
                ST_CALC: begin
                    p   <= step_sel[ADD_W-1:1];
                    q   <= {step_sel[0], q[N-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        product   <= {step_sel[N:0], q[N-1:1]};
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multu8_seq.sv
// ============================================================================
//  Module : tb_multu8_seq
//  Brief  : Scoreboard bench for multu8_seq with directed product vectors.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multu8_seq;
    import multu8_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          accept_cyc = 0;
    logic [15:0] exp_q[$];
    bit          rnd_ready = 1'b0;
    logic        prev_ov = 1'b0;

    multu8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops expected products on every accepted output.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (busy) chk("add_msb", 32'(dut.add_out[9]), 32'd0);
            if (out_valid) chk("ov_state", 32'(dut.state), 32'(ST_DONE));
            if (out_valid && !prev_ov) chk("latency", 32'(cyc - accept_cyc), 32'd8);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else chk("product", 32'(product), 32'(exp_q.pop_front()));
            end
            prev_ov = out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] expv, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            a = x; b = y; in_valid = 1'b1;
            if (push) exp_q.push_back(expv);
            @(posedge clk); #1;
            accept_cyc = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ra, rb;
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        #1;
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        issue(8'd13, 8'd11, 16'h008F, 1'b1);
        @(negedge clk);
        chk("calc_busy", 32'(busy), 32'd1);
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        wait_idle();
        issue(8'd255, 8'd255, 16'hFE01, 1'b1); wait_idle();
        issue(8'd128, 8'd2,   16'h0100, 1'b1); wait_idle();
        issue(8'd0,   8'd200, 16'h0000, 1'b1); wait_idle();

        // Back-pressure hold
        out_ready = 1'b0;
        issue(8'd77, 8'd3, 16'h00E7, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_product", 32'(product), 32'h00E7);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_ov", 32'(out_valid), 32'd0);

        // Operand changes while busy must not disturb the accepted job
        issue(8'd200, 8'd1, 16'h00C8, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 8'(8'h11 * (i + 1)); b = 8'(8'h23 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-calculation aborts the job
        issue(8'd200, 8'd200, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        chk("abort_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        issue(8'd9, 8'd9, 16'h0051, 1'b1); wait_idle();

        // Back-to-back directed vectors
        issue(8'd170, 8'd85,  16'h3872, 1'b1);
        issue(8'd1,   8'd255, 16'h00FF, 1'b1);
        issue(8'd255, 8'd1,   16'h00FF, 1'b1);
        issue(8'd16,  8'd16,  16'h0100, 1'b1);
        wait_idle();

        // Random operands with random downstream back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, 16'(ra) * 16'(rb), 1'b1);
        end
        rnd_ready = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
